l2_bank_req_arbiter: RTL and testbench

- Sits directly upstream of one L2 SRAM bank port (csn/wen/be/add/wdata/rdata, active-low chip select and write enable, 1-cycle read latency).
- Arbitrates NB_MASTERS TCDM-style requesters (req/gnt, then r_valid/r_rdata) onto that single bank port using round-robin.
- Routes each response back to the master that was granted. One instance per interleaved bank.

---
 rtl/l2_arb_pkg.sv | 20 ++
 rtl/l2_rr_arb.sv | 36 +++
 rtl/l2_bank_req_arbiter.sv | 122 ++++++++++++
 tb/tb_l2_bank_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 bank request arbiter.
// L2_ARB_RDATA_PIPE_EN selects the registered read-data response path.
package l2_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int TAG_W = $clog2(MAX_MASTERS);

  // Sized for the largest supported master count so one type fits all instances
  typedef logic [TAG_W-1:0] tag_t;

`ifdef L2_ARB_RDATA_PIPE_EN
  localparam int RESP_LATENCY = 2;
`else
  localparam int RESP_LATENCY = 1;
`endif

  localparam logic CSN_IDLE = 1'b1;
  localparam logic WEN_IDLE = 1'b1;

endpackage

// File: rtl/l2_rr_arb.sv
// Round-robin arbiter: first request at or after ptr wins.
// Produces a one-hot grant and the encoded winner index.
module l2_rr_arb
  import l2_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  tag_t         ptr,
  output logic [N-1:0] gnt,
  output tag_t         idx,
  output logic         valid
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = tag_t'(j);
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/l2_bank_req_arbiter.sv
// Round-robin arbiter of TCDM masters onto one L2 SRAM bank port.
// L2_ARB_RDATA_PIPE_EN adds a response register stage (2-cycle latency).
module l2_bank_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_MASTERS-1:0]                  req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  add_i,
  input  logic [NB_MASTERS-1:0]                  wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NB_MASTERS-1:0]                  gnt_o,
  output logic [NB_MASTERS-1:0]                  r_valid_o,
  output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  r_rdata_o,
  output logic                                   mem_csn_o,
  output logic                                   mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [ADDR_WIDTH-1:0]                  mem_add_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

  logic [NB_MASTERS-1:0] gnt;
  tag_t                  win;
  logic                  any;
  tag_t                  rr_ptr_q;
  logic                  resp_valid_q;
  tag_t                  tag_q;
  logic                  is_read_q;
  logic                  out_valid;
  tag_t                  out_tag;
  logic [DATA_WIDTH-1:0] out_data;

  l2_rr_arb #(
    .N(NB_MASTERS)
  ) u_arb (
    .req  (req_i),
    .ptr  (rr_ptr_q),
    .gnt  (gnt),
    .idx  (win),
    .valid(any)
  );

  assign gnt_o = gnt;

  // One-hot AND-OR mux keeps losing masters off the bank bus
  always_comb begin
    mem_csn_o   = CSN_IDLE;
    mem_wen_o   = WEN_IDLE;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (gnt[i]) begin
        mem_csn_o   = 1'b0;
        mem_wen_o   = wen_i[i];
        mem_be_o    = be_i[i];
        mem_add_o   = add_i[i];
        mem_wdata_o = wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      tag_q        <= '0;
      is_read_q    <= 1'b0;
    end else begin
      resp_valid_q <= any;
      if (any) begin
        tag_q     <= win;
        is_read_q <= mem_wen_o;
        rr_ptr_q  <= (int'(win) == NB_MASTERS - 1) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef L2_ARB_RDATA_PIPE_EN
  logic                  out_valid_q;
  tag_t                  out_tag_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= resp_valid_q;
      out_tag_q   <= tag_q;
      out_data_q  <= (resp_valid_q && is_read_q) ? mem_rdata_i : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
`else
  assign out_valid = resp_valid_q;
  assign out_tag   = tag_q;
  assign out_data  = is_read_q ? mem_rdata_i : '0;
`endif

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (out_valid && out_tag == tag_t'(i)) begin
        r_valid_o[i] = 1'b1;
        r_rdata_o[i] = out_data;
      end
    end
  end

endmodule

// File: tb/tb_l2_bank_req_arbiter.sv
// Directed bench for l2_bank_req_arbiter with a simple SRAM bank model.
// Expected latency follows RESP_LATENCY (L2_ARB_RDATA_PIPE_EN aware).
module tb_l2_bank_req_arbiter;
  import l2_arb_pkg::*;

  localparam int L = RESP_LATENCY;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req;
  logic [1:0][13:0] add;
  logic [1:0]       wen;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt;
  logic [1:0]       r_valid;
  logic [1:0][31:0] r_rdata;
  logic             mem_csn;
  logic             mem_wen;
  logic [3:0]       mem_be;
  logic [13:0]      mem_add;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = '0;

  logic [31:0] mem [0:16383];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  l2_bank_req_arbiter #(
    .NB_MASTERS(2),
    .ADDR_WIDTH(14),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .add_i      (add),
    .wen_i      (wen),
    .be_i       (be),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .r_valid_o  (r_valid),
    .r_rdata_o  (r_rdata),
    .mem_csn_o  (mem_csn),
    .mem_wen_o  (mem_wen),
    .mem_be_o   (mem_be),
    .mem_add_o  (mem_add),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always @(posedge clk) begin
    if (!mem_csn) begin
      if (!mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_add][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_add];
      end
    end
  end

  task automatic clear_inputs();
    req   = 2'b00;
    add   = {14'h3FFF, 14'h3FFF};
    wen   = 2'b00;
    be    = {4'hF, 4'hF};
    wdata = {32'hBAD0BAD0, 32'hBAD1BAD1};
  endtask

  task automatic drive(input int m, input logic rd, input logic [13:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[m]   = 1'b1;
    wen[m]   = rd;
    add[m]   = a;
    be[m]    = b;
    wdata[m] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_csn, mem_wen, mem_be} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_bank: got csn=%b wen=%b be=%h want 1 1 0",
               mem_csn, mem_wen, mem_be);
    end
    total++;
    if ({mem_add, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_addr_data: got %h %h want 0 0", mem_add, mem_wdata);
    end
    total++;
    if (gnt !== 2'b00 || r_valid !== 2'b00 || r_rdata !== '0) begin
      bad++;
      $display("FAIL reset_resp: got gnt=%b rv=%b rd=%h want 0", gnt, r_valid, r_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (mem_csn !== 1'b1 || gnt !== 2'b00 || r_valid !== 2'b00) begin
      bad++;
      $display("FAIL idle: got csn=%b gnt=%b rv=%b want 1 00 00", mem_csn, gnt, r_valid);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    clear_inputs();
    drive(0, 1'b0, 14'h0010, 4'hF, 32'hDEADBEEF);
    #1;
    total++;
    if (gnt !== 2'b01 || mem_csn !== 1'b0 || mem_wen !== 1'b0 ||
        mem_add !== 14'h0010 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin
      bad++;
      $display("FAIL wr_issue: got gnt=%b csn=%b wen=%b add=%h wd=%h be=%h",
               gnt, mem_csn, mem_wen, mem_add, mem_wdata, mem_be);
    end
    @(negedge clk);
    clear_inputs();
    repeat (L - 1) @(negedge clk);
    #1;
    total++;
    if (r_valid !== 2'b01 || r_rdata !== '0) begin
      bad++;
      $display("FAIL wr_resp: got rv=%b rd=%h want 01 0", r_valid, r_rdata);
    end
    @(negedge clk);
    clear_inputs();
    drive(0, 1'b1, 14'h0010, 4'hF, 32'h0);
    #1;
    total++;
    if (gnt !== 2'b01 || mem_csn !== 1'b0 || mem_wen !== 1'b1) begin
      bad++;
      $display("FAIL rd_issue: got gnt=%b csn=%b wen=%b want 01 0 1", gnt, mem_csn, mem_wen);
    end
    @(negedge clk);
    clear_inputs();
    repeat (L - 1) @(negedge clk);
    #1;
    total++;
    if (r_valid !== 2'b01 || r_rdata[0] !== 32'hDEADBEEF || r_rdata[1] !== '0) begin
      bad++;
      $display("FAIL rd_resp: got rv=%b rd0=%h rd1=%h want 01 deadbeef 0",
               r_valid, r_rdata[0], r_rdata[1]);
    end
  endtask

  task automatic test_rotation();
    logic [1:0]  hist [0:15];
    logic [1:0]  exp_g;
    logic [1:0]  exp_v;
    logic [31:0] val [0:1];
    logic [31:0] exp_d;
    int          nresp;
    do_reset();
    mem[14'h20] = 32'hA0A00000;
    mem[14'h21] = 32'hB1B11111;
    val[0] = 32'hA0A00000;
    val[1] = 32'hB1B11111;
    nresp = 0;
    for (int c = 0; c < 6 + L; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c < 6) begin
        drive(0, 1'b1, 14'h0020, 4'hF, 32'h0);
        drive(1, 1'b1, 14'h0021, 4'hF, 32'h0);
      end
      #1;
      exp_g = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      hist[c] = exp_g;
      total++;
      if (gnt !== exp_g) begin
        bad++;
        $display("FAIL rot_gnt[%0d]: got %b want %b", c, gnt, exp_g);
      end
      if (c >= L) begin
        exp_v = hist[c - L];
        total++;
        if (r_valid !== exp_v) begin
          bad++;
          $display("FAIL rot_rv[%0d]: got %b want %b", c, r_valid, exp_v);
        end
        for (int m = 0; m < 2; m++) begin
          exp_d = exp_v[m] ? val[m] : 32'h0;
          total++;
          if (r_rdata[m] !== exp_d) begin
            bad++;
            $display("FAIL rot_rd[%0d][%0d]: got %h want %h", c, m, r_rdata[m], exp_d);
          end
        end
        if (r_valid != 2'b00) nresp++;
      end
    end
    total++;
    if (nresp != 6) begin
      bad++;
      $display("FAIL rot_count: got %0d want 6", nresp);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_g;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      drive(1, 1'b1, 14'h0021, 4'hF, 32'h0);
      if (c >= 4) drive(0, 1'b1, 14'h0020, 4'hF, 32'h0);
      #1;
      exp_g = (c == 4) ? 2'b01 : 2'b10;
      total++;
      if (gnt !== exp_g) begin
        bad++;
        $display("FAIL single_gnt[%0d]: got %b want %b", c, gnt, exp_g);
      end
    end
    @(negedge clk);
    clear_inputs();
    repeat (L + 1) @(negedge clk);
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    clear_inputs();
    drive(1, 1'b0, 14'h0030, 4'hF, 32'h11223344);
    @(negedge clk);
    clear_inputs();
    drive(1, 1'b0, 14'h0030, 4'h2, 32'h0000AB00);
    #1;
    total++;
    if (mem_add !== 14'h0030 || mem_be !== 4'h2 || mem_wdata !== 32'h0000AB00) begin
      bad++;
      $display("FAIL bw_issue: got add=%h be=%h wd=%h want 0030 2 0000ab00",
               mem_add, mem_be, mem_wdata);
    end
    @(negedge clk);
    clear_inputs();
    drive(1, 1'b1, 14'h0030, 4'hF, 32'h0);
    @(negedge clk);
    clear_inputs();
    repeat (L - 1) @(negedge clk);
    #1;
    total++;
    if (r_valid !== 2'b10 || r_rdata[1] !== 32'h1122AB44 || r_rdata[0] !== '0) begin
      bad++;
      $display("FAIL bw_resp: got rv=%b rd1=%h rd0=%h want 10 1122ab44 0",
               r_valid, r_rdata[1], r_rdata[0]);
    end
    total++;
    if (mem_csn !== 1'b1 || mem_add !== '0 || mem_wdata !== '0 || mem_be !== '0) begin
      bad++;
      $display("FAIL dont_care: got csn=%b add=%h wd=%h be=%h want idle",
               mem_csn, mem_add, mem_wdata, mem_be);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_inputs();
    drive(0, 1'b1, 14'h0030, 4'hF, 32'h0);
    @(posedge clk);
    #2;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    total++;
    if (r_valid !== 2'b00 || r_rdata !== '0) begin
      bad++;
      $display("FAIL rst_mid: got rv=%b rd=%h want 00 0", r_valid, r_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (r_valid !== 2'b00) begin
        bad++;
        $display("FAIL rst_drop[%0d]: got rv=%b want 00", c, r_valid);
      end
    end
    @(negedge clk);
    clear_inputs();
    drive(0, 1'b1, 14'h0030, 4'hF, 32'h0);
    drive(1, 1'b1, 14'h0021, 4'hF, 32'h0);
    #1;
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL rst_ptr: got gnt=%b want 01", gnt);
    end
    @(negedge clk);
    clear_inputs();
    repeat (L + 1) @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_rotation();
    test_single();
    test_byte_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
